// File: rtl/addsub_accum_pkg.sv
// addsub_accum shared types: opcode enum and stage-1 payload.
// Operand fields are sized to OPND_MAX; the unit's WIDTH must not exceed it.
package addsub_accum_pkg;

  localparam int OPND_MAX = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef struct packed {
    op_e                 op;
    logic [OPND_MAX-1:0] a;
    logic [OPND_MAX-1:0] b;
  } s1_t;

endpackage

// File: rtl/addsub_accum_if.sv
// addsub_accum request/response bundle with valid/ready on both sides.
// master drives operations and consumes results; slave is the unit.
interface addsub_accum_if
  import addsub_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             carry;
  logic             ovf_sticky;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, ovf_sticky
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, ovf_sticky
  );

endinterface

// File: rtl/addsub_accum_alu.sv
// addsub_accum combinational datapath: add, subtract, accumulate, clear.
// ADDSUB_ACCUM_SATURATE_EN selects clamping instead of wrapping.
module addsub_accum_alu
  import addsub_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [ACC_W-1:0] i_acc,
  output logic [ACC_W-1:0] o_result,
  output logic             o_carry,
  output logic [ACC_W-1:0] o_acc_next,
  output logic             o_acc_we
);

`ifdef ADDSUB_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [ACC_W-1:0] MAXV = '1;

  logic [ACC_W-1:0] w_az;
  logic [ACC_W-1:0] w_bz;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_acc_sum;
  logic [ACC_W-1:0] w_diff;
  logic             w_borrow;

  assign w_az      = ACC_W'(i_a);
  assign w_bz      = ACC_W'(i_b);
  assign w_sum     = {1'b0, w_az} + {1'b0, w_bz};
  assign w_diff    = w_az - w_bz;
  assign w_borrow  = i_a < i_b;
  assign w_acc_sum = {1'b0, i_acc} + {1'b0, w_az};

  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_acc_next = i_acc;
    o_acc_we   = 1'b0;
    unique case (1'b1)
      (i_op == OP_ADD): begin
        o_carry  = w_sum[WIDTH];
        o_result = (SAT && w_sum[ACC_W]) ? MAXV
                                         : w_sum[ACC_W-1:0];
      end
      (i_op == OP_SUB): begin
        o_carry  = w_borrow;
        o_result = (SAT && w_borrow) ? '0 : w_diff;
      end
      (i_op == OP_ACC): begin
        o_carry    = w_acc_sum[ACC_W];
        o_acc_next = (SAT && w_acc_sum[ACC_W]) ? MAXV
                                               : w_acc_sum[ACC_W-1:0];
        o_result   = o_acc_next;
        o_acc_we   = 1'b1;
      end
      (i_op == OP_CLR): begin
        o_acc_next = '0;
        o_acc_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/addsub_accum.sv
// addsub_accum top: two-stage add/sub/accumulate pipeline with backpressure.
// Saturating arithmetic is built when ADDSUB_ACCUM_SATURATE_EN is defined.
module addsub_accum
  import addsub_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input logic           clk,
  input logic           reset,
  addsub_accum_if.slave bus
);

  logic             r_s1_vld;
  s1_t              r_s1;
  logic             r_s2_vld;
  logic [ACC_W-1:0] r_res;
  logic             r_carry;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_push;
  logic [ACC_W-1:0] w_res;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_acc_we;
  logic [2*OPND_MAX-1:0] w_unused_s1;

  assign w_unused_s1  = {r_s1.a, r_s1.b};

  assign w_s2_adv     = !r_s2_vld || bus.out_ready;
  assign w_s1_adv     = !r_s1_vld || w_s2_adv;
  assign bus.in_ready = !reset && w_s1_adv;
  assign w_push       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= w_push;
      if (w_push) begin
        r_s1.op <= bus.op;
        r_s1.a  <= OPND_MAX'(bus.a);
        r_s1.b  <= OPND_MAX'(bus.b);
      end
    end
  end

  addsub_accum_alu #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_alu (
    .i_op       (r_s1.op),
    .i_a        (r_s1.a[WIDTH-1:0]),
    .i_b        (r_s1.b[WIDTH-1:0]),
    .i_acc      (r_acc),
    .o_result   (w_res),
    .o_carry    (w_carry),
    .o_acc_next (w_acc_next),
    .o_acc_we   (w_acc_we)
  );

  // acc commits as its op leaves stage 1, so the next ACC sees it at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld <= 1'b0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_res   <= w_res;
        r_carry <= w_carry;
        if (w_acc_we) r_acc <= w_acc_next;
        if (r_s1.op == OP_CLR) r_ovf <= 1'b0;
        else if (r_s1.op == OP_ACC && w_carry) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = r_s2_vld;
  assign bus.result     = r_res;
  assign bus.carry      = r_carry;
  assign bus.ovf_sticky = r_ovf;

endmodule
